// File: rtl/led_scan_ctrl_if.sv
// Pattern load handshake, run request and LED matrix drive outputs of led_scan_ctrl.
// master = pattern source / controller side, slave = the scan controller.
interface led_scan_ctrl_if;
    logic         enable;
    logic [255:0] pattern_in;
    logic         pattern_valid;
    logic         pattern_ready;
    logic [15:0]  row_sel;
    logic [15:0]  col_data;
    logic         frame_done;

    modport master (
        output enable, pattern_in, pattern_valid,
        input  pattern_ready, row_sel, col_data, frame_done
    );

    modport slave (
        input  enable, pattern_in, pattern_valid,
        output pattern_ready, row_sel, col_data, frame_done
    );
endinterface

// File: rtl/led_scan_ctrl.sv
// 16x16 LED matrix row scanner with double-buffered frame image; new images swap in at frame start.
// Macro LED_SCAN_BLANK_EN adds a BLANK_TICKS dark gap after every row; undefined, rows scan back to back.
module led_scan_ctrl #(
    parameter int ROW_TICKS   = 1000,
    parameter int BLANK_TICKS = 4
) (
    input  logic           clk,
    input  logic           reset,
    led_scan_ctrl_if.slave bus
);
    localparam int MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
    localparam int TICK_W    = $clog2(MAX_TICKS);

    localparam logic [TICK_W-1:0] ROW_LAST = TICK_W'(ROW_TICKS - 1);
`ifdef LED_SCAN_BLANK_EN
    localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_TICKS - 1);
    localparam logic [TICK_W-1:0] BLANK_PEN  = (BLANK_TICKS >= 2) ? TICK_W'(BLANK_TICKS - 2) : '0;
`else
    localparam logic [TICK_W-1:0] ROW_PEN = TICK_W'(ROW_TICKS - 2);
`endif

    typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;

    state_t              state_q;
    logic [3:0]          row_q;
    logic [TICK_W-1:0]   tick_q;
    logic [255:0]        shadow_q;
    logic [255:0]        active_q;
    logic                shadow_full_q;
    logic [15:0]         row_sel_q;
    logic [15:0]         col_data_q;
    logic                frame_done_q;

    logic                last_row;
    logic                at_boundary;
    logic                capture;
    logic                swap;
    logic [255:0]        frame_img;

    state_t              state_d;
    logic [3:0]          row_d;
    logic [15:0]         row_sel_d;
    logic [15:0]         col_data_d;

    assign last_row = (row_q == 4'd15);
`ifdef LED_SCAN_BLANK_EN
    assign at_boundary = (state_q == BLANK) && (tick_q == BLANK_LAST) && last_row;
`else
    assign at_boundary = (state_q == SCAN) && (tick_q == ROW_LAST) && last_row;
`endif
    assign capture   = bus.pattern_valid && !shadow_full_q;
    assign swap      = shadow_full_q && (((state_q == IDLE) && bus.enable) || at_boundary);
    // Row 0 of a new frame must show the image being swapped in on the same edge.
    assign frame_img = shadow_full_q ? shadow_q : active_q;

    // Where the scan goes when the current row's last phase ends.
    always_comb begin
        state_d    = SCAN;
        row_d      = row_q + 4'd1;
        row_sel_d  = 16'b1 << row_d;
        col_data_d = active_q[{row_d, 4'b0000} +: 16];
        if (last_row) begin
            row_d = 4'd0;
            if (bus.enable) begin
                row_sel_d  = 16'h0001;
                col_data_d = frame_img[15:0];
            end else begin
                state_d    = IDLE;
                row_sel_d  = 16'h0000;
                col_data_d = 16'h0000;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            row_q         <= 4'd0;
            tick_q        <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            shadow_full_q <= 1'b0;
            row_sel_q     <= 16'h0000;
            col_data_q    <= 16'h0000;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // capture needs an empty shadow and swap a full one, so they never collide.
            if (capture) begin
                shadow_q      <= bus.pattern_in;
                shadow_full_q <= 1'b1;
            end
            if (swap) begin
                active_q      <= shadow_q;
                shadow_full_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    row_sel_q  <= 16'h0000;
                    col_data_q <= 16'h0000;
                    if (bus.enable) begin
                        state_q    <= SCAN;
                        row_q      <= 4'd0;
                        tick_q     <= '0;
                        row_sel_q  <= 16'h0001;
                        col_data_q <= frame_img[15:0];
                    end
                end
`ifdef LED_SCAN_BLANK_EN
                SCAN: begin
                    if (tick_q == ROW_LAST) begin
                        state_q      <= BLANK;
                        tick_q       <= '0;
                        row_sel_q    <= 16'h0000;
                        col_data_q   <= 16'h0000;
                        frame_done_q <= last_row && (BLANK_TICKS == 1);
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                BLANK: begin
                    if (tick_q == BLANK_LAST) begin
                        state_q    <= state_d;
                        row_q      <= row_d;
                        tick_q     <= '0;
                        row_sel_q  <= row_sel_d;
                        col_data_q <= col_data_d;
                    end else begin
                        tick_q       <= tick_q + 1'b1;
                        frame_done_q <= last_row && (BLANK_TICKS >= 2) && (tick_q == BLANK_PEN);
                    end
                end
`else
                SCAN: begin
                    if (tick_q == ROW_LAST) begin
                        state_q    <= state_d;
                        row_q      <= row_d;
                        tick_q     <= '0;
                        row_sel_q  <= row_sel_d;
                        col_data_q <= col_data_d;
                    end else begin
                        tick_q       <= tick_q + 1'b1;
                        frame_done_q <= last_row && (tick_q == ROW_PEN);
                    end
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    row_q      <= 4'd0;
                    tick_q     <= '0;
                    row_sel_q  <= 16'h0000;
                    col_data_q <= 16'h0000;
                end
            endcase
        end
    end

    // frame_done is raised on the edge entering the frame's final cycle.
    assign bus.pattern_ready = !shadow_full_q;
    assign bus.row_sel       = row_sel_q;
    assign bus.col_data      = col_data_q;
    assign bus.frame_done    = frame_done_q;
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Random-stimulus bench for led_scan_ctrl against a frame-position reference model.
// Follows LED_SCAN_BLANK_EN so the same bench covers both builds.
module tb_led_scan_ctrl;
    localparam int R = 4;
`ifdef LED_SCAN_BLANK_EN
    localparam int B = 2;
`else
    localparam int B = 0;
`endif
    localparam int SLOT   = R + B;
    localparam int PERIOD = 16 * SLOT;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_scan_ctrl_if bus ();

    led_scan_ctrl #(.ROW_TICKS(R), .BLANK_TICKS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_fd  = -1;
    bit gap_on   = 1'b0;

    logic [255:0] m_shadow, m_active;
    bit           m_full, m_run;
    int           m_pos;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        m_shadow = '0; m_active = '0; m_full = 1'b0; m_run = 1'b0; m_pos = 0;
    endtask

    task automatic model_edge(input bit en, input bit vld, input logic [255:0] pat);
        bit old_full;
        bit do_swap;
        old_full = m_full;
        do_swap  = 1'b0;
        if (m_run) begin
            if (m_pos == PERIOD - 1) begin
                do_swap = old_full;
                m_pos   = 0;
                m_run   = en;
            end else begin
                m_pos++;
            end
        end else if (en) begin
            m_run   = 1'b1;
            m_pos   = 0;
            do_swap = old_full;
        end
        if (do_swap) begin
            m_active = m_shadow;
            m_full   = 1'b0;
        end
        if (vld && !old_full) begin
            m_shadow = pat;
            m_full   = 1'b1;
        end
    endtask

    task automatic compare();
        logic [15:0] ers, ecd;
        logic        efd;
        int          r, ph;
        ers = '0; ecd = '0; efd = 1'b0;
        if (m_run) begin
            r  = m_pos / SLOT;
            ph = m_pos % SLOT;
            if (ph < R) begin
                ers = 16'(1 << r);
                ecd = m_active[r*16 +: 16];
            end
            efd = (m_pos == PERIOD - 1);
        end
        chk("row_sel", 32'(bus.row_sel), 32'(ers));
        chk("col_data", 32'(bus.col_data), 32'(ecd));
        chk("frame_done", 32'(bus.frame_done), 32'(efd));
        chk("pattern_ready", 32'(bus.pattern_ready), 32'(!m_full));
    endtask

    task automatic cycle(input bit en, input bit vld, input logic [255:0] pat);
        bus.enable        = en;
        bus.pattern_valid = vld;
        bus.pattern_in    = pat;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(en, vld, pat);
        compare();
        if (gap_on && bus.frame_done) begin
            if (last_fd >= 0) chk("fd_period", 32'(cyc - last_fd), 32'(PERIOD));
            last_fd = cyc;
        end
    endtask

    initial begin
        logic [255:0] p0;
        bit           en;
        int           n;

        reset = 1'b1;
        bus.enable = 1'b0; bus.pattern_valid = 1'b0; bus.pattern_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        reset = 1'b0;

        // Frame image with distinctive first and last rows, then start scanning.
        p0 = rand256();
        p0[15:0]    = 16'hFFFF;
        p0[255:240] = 16'h8001;
        cycle(1'b0, 1'b1, p0);
        chk("ready_low_after_load", 32'(bus.pattern_ready), 32'd0);
        gap_on = 1'b1;
        cycle(1'b1, 1'b0, '0);
        chk("first_row_sel", 32'(bus.row_sel), 32'h0001);
        chk("first_col", 32'(bus.col_data), 32'hFFFF);
        for (int i = 1; i <= 3 * PERIOD + 10; i++) begin
            cycle(1'b1, (i > PERIOD) && ($urandom_range(0, 39) == 0), rand256());
            if (i == R - 1) chk("row0_hold", 32'(bus.col_data), 32'hFFFF);
            if (i == R) chk("after_row0_sel", 32'(bus.row_sel), (B > 0) ? 32'h0000 : 32'h0002);
            if (i == 15 * SLOT) begin
                chk("row15_sel", 32'(bus.row_sel), 32'h8000);
                chk("row15_col", 32'(bus.col_data), 32'h8001);
            end
        end
        gap_on = 1'b0;

        // Drop enable partway into row 5; the frame must finish before idling.
        n = 0;
        while (!(m_run && m_pos == 5 * SLOT + 1) && n < 2 * PERIOD) begin
            cycle(1'b1, 1'b0, '0);
            n++;
        end
        chk("reach_row5", 32'(n < 2 * PERIOD), 32'd1);
        for (int i = 0; i < PERIOD + 20; i++)
            cycle(1'b0, $urandom_range(0, 29) == 0, rand256());
        chk("idle_row_sel", 32'(bus.row_sel), 32'd0);
        cycle(1'b1, 1'b0, '0);
        chk("restart_row0", 32'(bus.row_sel), 32'h0001);

        en = 1'b1;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            if ($urandom_range(0, 99) == 0) en = !en;
            cycle(en, $urandom_range(0, 24) == 0, rand256());
        end

        // Asynchronous reset at row 9 tick 2.
        n = 0;
        while (!(m_run && m_pos == 9 * SLOT + 2) && n < 3 * PERIOD) begin
            cycle(1'b1, $urandom_range(0, 24) == 0, rand256());
            n++;
        end
        chk("reach_row9", 32'(n < 3 * PERIOD), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_row_sel", 32'(bus.row_sel), 32'd0);
        chk("async_col", 32'(bus.col_data), 32'd0);
        chk("async_ready", 32'(bus.pattern_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        compare();
        reset = 1'b0;
        cycle(1'b1, 1'b0, '0);
        chk("post_rst_sel", 32'(bus.row_sel), 32'h0001);
        chk("post_rst_active", 32'(bus.col_data), 32'd0);

        en = 1'b1;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if ($urandom_range(0, 149) == 0) en = !en;
            cycle(en, $urandom_range(0, 19) == 0, rand256());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 Parameter ROW_TICKS, default 1000, clock cycles each row is driven (SHALL be >= 2).
REQ-002 Parameter BLANK_TICKS, default 4, clock cycles of dark gap after each row (SHALL be >= 1).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  scan run request.
REQ-006 pattern_in  input  256  frame image; row r = bits [r*16+:16], bit 15 of the slice = leftmost column.
REQ-007 pattern_valid  input  1  pattern_in offered.
REQ-008 pattern_ready  output  1  shadow buffer empty; transfer on valid&&ready.
REQ-009 row_sel  output  16  one-hot active-high row drive; bit r = row r.
REQ-010 col_data  output  16  column data for the driven row.
REQ-011 frame_done  output  1  one-cycle pulse at end of row 15.

Function
REQ-012 Two 256-bit buffers SHALL exist: shadow (written from the input) and active (displayed).
REQ-013 On valid&&ready, shadow SHALL capture pattern_in and pattern_ready SHALL drop the next cycle.
REQ-014 FSM states SHALL be IDLE, SCAN and BLANK.
REQ-015 IDLE: row_sel=0, col_data=0; if enable=1, next state SCAN with row=0 and tick=0.
REQ-016 On the IDLE->SCAN transition, a full shadow SHALL be copied to active and marked empty.
REQ-017 SCAN: row_sel=one-hot(row) and col_data=active[row], both registered, both valid the same cycle.
REQ-018 SCAN SHALL last exactly ROW_TICKS cycles per row, then enter BLANK.
REQ-019 BLANK: row_sel=0 and col_data=0 for exactly BLANK_TICKS cycles.
REQ-020 At the end of BLANK for rows 0-14, row SHALL increment and the FSM SHALL return to SCAN.
REQ-021 At the end of BLANK for row 15 (frame boundary): frame_done=1 for one cycle; row wraps to 0.
REQ-022 At the frame boundary, a full shadow SHALL be copied to active and pattern_ready SHALL rise the next cycle; an empty shadow leaves active unchanged.
REQ-023 A capture in the same cycle as a frame boundary with an empty shadow SHALL fill the shadow only; the swap SHALL occur at the following boundary.
REQ-024 enable is sampled only at a frame boundary: enable=0 goes to IDLE, enable=1 continues with row 0; a mid-frame deassert SHALL complete the frame.
REQ-025 Frame period SHALL be 16*(ROW_TICKS+BLANK_TICKS) cycles.
REQ-026 The tick counter SHALL be wide enough for max(ROW_TICKS, BLANK_TICKS)-1 with no wrap inside a phase.

Reset
REQ-027 On reset=1 (asynchronous), state SHALL be IDLE with row=0 and tick=0.
REQ-028 Reset values: both buffers all zeros, shadow empty, pattern_ready=1, row_sel=0, col_data=0, frame_done=0.
REQ-029 Reset mid-frame SHALL force outputs to 0 immediately, without waiting for a clock edge.
REQ-030 After reset deasserts, scanning SHALL restart from row 0 when enable=1.

Configuration
REQ-031 Macro LED_SCAN_BLANK_EN defined: BLANK state present as specified in REQ-019 to REQ-021.
REQ-032 Macro LED_SCAN_BLANK_EN undefined: BLANK state removed and BLANK_TICKS ignored.
REQ-033 Without the macro, SCAN SHALL move directly to the next row, frame events SHALL occur at the end of row 15 SCAN, and the frame period SHALL be 16*ROW_TICKS cycles.

Verification (ROW_TICKS=4, BLANK_TICKS=2, macro defined unless noted)
REQ-034 Reset, load a pattern with row0=16'hFFFF and row15=16'h8001, then set enable=1.
- Required: first SCAN cycle shows row_sel=16'h0001 and col_data=16'hFFFF for 4 cycles.
- Required: 2 dark cycles follow.
- Required: row 15 shows row_sel=16'h8000 and col_data=16'h8001.
REQ-035 Free run for 3 frames: frame_done pulses exactly every 96 cycles and is one cycle wide.
REQ-036 Load pattern B mid-frame: pattern_ready=0 until the boundary, rises 1 cycle after frame_done, and B is displayed from row 0 of the next frame.
REQ-037 Deassert enable at row 5: rows 6-15 still scan, then IDLE with row_sel=0 at the boundary; reassert restarts at row 0.
REQ-038 Assert reset at row 9 tick 2: row_sel=0 and pattern_ready=1 asynchronously, active=0 after release.
REQ-039 Macro undefined: row changes every 4 cycles with no dark gap, and frame_done pulses every 64 cycles.
